csa_mult_seq: RTL



---
 rtl/csa_mult_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/csa_mult_seq.sv
// Sequential unsigned multiplier: one shared row of full-adder cells accumulates a
// partial product per cycle in carry-save form, then ripples the final sum.
module csa_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    s_r;
    // Top carry bit would only ever be shifted out, so it is not stored.
    logic [PW-2:0]    c_r;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    y_op;
    logic [PW-1:0]    fa_s;
    logic [PW-2:0]    fa_c;
    logic             resolving;

    assign resolving = (state == ST_RESOLVE);
    assign y_op      = {c_r, 1'b0};

    always_comb begin
        pp = '0;
        if (b_r[cnt])
            pp = {{WIDTH{1'b0}}, a_r} << cnt;
    end

    // The same cell row serves both phases: the third input is the partial
    // product while accumulating and the neighbour's carry while resolving.
    always_comb begin
        logic xi, yi, zi, rc;
        fa_s = '0;
        fa_c = '0;
        rc   = 1'b0;
        for (int unsigned i = 0; i < PW; i++) begin
            xi      = s_r[i];
            yi      = y_op[i];
            zi      = resolving ? rc : pp[i];
            fa_s[i] = xi ^ yi ^ zi;
            rc      = (xi & yi) | (xi & zi) | (yi & zi);
            if (i < PW - 1)
                fa_c[i] = rc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            c_r     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    s_r <= fa_s;
                    c_r <= fa_c;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= ST_RESOLVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    product <= fa_s;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                default: begin
                    // DONE also accepts a new start so back-to-back requests
                    // sustain one operation every WIDTH+2 cycles.
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        s_r   <= '0;
                        c_r   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ACCUM;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
